// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants, transmitter state type and parity helper
package ps2_pkg;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {IDLE, HOLD, BIT_HI, BIT_LO, GAP} tx_state_t;

    // Parity bit that makes the count of ones over data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and full/empty flags
//   clk_sys, reset  clock, synchronous active-high reset (flushes contents)
//   push, wdata     write request and data; ignored while full
//   pop             read request; ignored while empty
//   rdata           head entry (valid while !empty)
//   full, empty     occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // The extra pointer bit tells a full ring from an empty one.
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= (push && !full) ? wptr + (AW+1)'(1) : wptr;
            rptr <= (pop && !empty) ? rptr + (AW+1)'(1) : rptr;
        end
    end

    always_ff @(posedge clk_sys)
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;

endmodule

// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: PS/2 device-side transmitter with byte FIFO, odd parity, host-inhibit abort and retry
//   clk_sys, reset             system clock, synchronous active-high reset
//   din, din_valid, din_ready  byte push into the FIFO; din_ready = FIFO not full
//   ps2_clk_out, ps2_data_out  PS/2 lines driven by this block (1 = released)
//   ps2_clk_in                 wired PS/2 clock; low while released means host inhibit
//   busy                       frame in progress or FIFO non-empty
//   overflow                   one-cycle pulse when a push is dropped on a full FIFO
module ps2_dev_tx
    import ps2_pkg::*;
#(
    parameter int HALF_CYC   = 859,
    parameter int GAP_CYC    = 1074,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    input  logic       ps2_clk_in,
    output logic       busy,
    output logic       overflow
);
    localparam int              HW          = $clog2(HALF_CYC + 1);
    localparam int              GW          = $clog2(GAP_CYC + 1);
    localparam logic [HW-1:0]   HALF_LAST   = HW'(HALF_CYC - 1);
    localparam logic [GW-1:0]   GAP_LOAD    = GW'(GAP_CYC);
    localparam logic [3:0]      LAST_IDX    = 4'(FRAME_BITS - 1);
    localparam logic [3:0]      ABORT_MAX   = 4'(FRAME_BITS - 2);
    // Our own clock release needs two cycles to come back through the synchroniser.
    localparam logic [HW-1:0]   SYNC_SETTLE = HW'(2);

    tx_state_t             state, state_nx;
    logic [HW-1:0]         hcnt, hcnt_nx;
    logic [GW-1:0]         gcnt, gcnt_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    logic [3:0]            idx, idx_nx;
    logic                  clk_m, clk_s;
    logic                  pop, full, empty, half_done;
    logic [7:0]            head;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (din_valid),
        .wdata   (din),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    assign din_ready = !full;
    assign busy      = (state != IDLE) || !empty;
    assign half_done = hcnt == HALF_LAST;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_m    <= 1'b1;
            clk_s    <= 1'b1;
            state    <= IDLE;
            hcnt     <= '0;
            gcnt     <= GAP_LOAD;
            shreg    <= '1;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            clk_m    <= ps2_clk_in;
            clk_s    <= clk_m;
            state    <= state_nx;
            hcnt     <= hcnt_nx;
            gcnt     <= gcnt_nx;
            shreg    <= shreg_nx;
            idx      <= idx_nx;
            overflow <= din_valid && full;
        end
    end

    always_comb begin
        state_nx     = state;
        hcnt_nx      = hcnt;
        gcnt_nx      = gcnt;
        shreg_nx     = shreg;
        idx_nx       = idx;
        pop          = 1'b0;
        ps2_clk_out  = 1'b1;
        ps2_data_out = 1'b1;
        case (state)
            IDLE: begin
                // An inhibiting host restarts the idle gap; it only runs down with the clock high.
                gcnt_nx  = !clk_s ? GAP_LOAD : (gcnt != '0 ? gcnt - GW'(1) : gcnt);
                state_nx = (!empty && gcnt == '0 && clk_s) ? HOLD : IDLE;
            end
            HOLD: begin
                ps2_data_out = START_BIT;
                shreg_nx     = {STOP_BIT, odd_parity(head), head, START_BIT};
                idx_nx       = '0;
                hcnt_nx      = '0;
                state_nx     = BIT_HI;
            end
            BIT_HI: begin
                ps2_data_out = shreg[0];
                hcnt_nx      = half_done ? '0 : hcnt + HW'(1);
                // Host inhibit before the stop bit aborts; the byte stays queued for a retry.
                state_nx     = (hcnt >= SYNC_SETTLE && !clk_s && idx <= ABORT_MAX) ? GAP :
                               half_done ? BIT_LO : BIT_HI;
            end
            BIT_LO: begin
                ps2_clk_out  = 1'b0;
                ps2_data_out = shreg[0];
                hcnt_nx      = half_done ? '0 : hcnt + HW'(1);
                if (half_done) begin
                    pop      = idx == LAST_IDX;
                    state_nx = idx == LAST_IDX ? GAP : BIT_HI;
                    shreg_nx = idx == LAST_IDX ? shreg : {1'b1, shreg[FRAME_BITS-1:1]};
                    idx_nx   = idx == LAST_IDX ? idx : idx + 4'd1;
                end
            end
            GAP: begin
                gcnt_nx  = GAP_LOAD;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb_ps2_dev_tx: directed and randomized checks of the PS/2 device transmitter against a frame model
module tb_ps2_dev_tx;
    localparam int HALF = 17;
    localparam int GAP  = 41;
    localparam int LIM  = 4000;
    // Release to first data fall: two synchroniser flops plus the IDLE->HOLD register.
    localparam int SYNC = 3;

    logic       clk_sys   = 1'b0;
    logic       reset     = 1'b1;
    logic       din_valid = 1'b0;
    logic       host_clk  = 1'b1;
    logic [7:0] din       = 8'h00;
    logic       din_ready, ps2_clk_out, ps2_data_out, ps2_clk_in, busy, overflow;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] q[$];

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Wired-AND bus: the host can hold the clock low regardless of our drive.
    assign ps2_clk_in = ps2_clk_out & host_clk;

    ps2_dev_tx #(.HALF_CYC(HALF), .GAP_CYC(GAP), .FIFO_DEPTH(8)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .ps2_clk_in   (ps2_clk_in),
        .busy         (busy),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as the host sees it, one entry per falling edge: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        while (ps2_clk_out !== lvl && n < LIM) begin
            step(1);
            n++;
        end
    endtask

    task automatic get_frame(output logic [10:0] bits, output int low_len, output int span, output bit tmo);
        int n, t0;
        bits = '0; low_len = 0; span = 0; tmo = 1'b0; t0 = 0;
        for (int k = 0; k < 11; k++) begin
            wait_level(1'b0, n);
            if (ps2_clk_out !== 1'b0) begin tmo = 1'b1; return; end
            if (k == 0) t0 = cyc;
            bits[k] = ps2_data_out;
            wait_level(1'b1, n);
            if (ps2_clk_out !== 1'b1) begin tmo = 1'b1; return; end
            low_len = (k == 0) ? n : (n == low_len ? low_len : -1);
        end
        span = cyc - t0;
    endtask

    task automatic drain(input int n);
        logic [10:0] bits;
        int low, span;
        bit tmo;
        for (int i = 0; i < n; i++) begin
            get_frame(bits, low, span, tmo);
            chk("drain_timeout", 32'(tmo), 0);
            chk("drain_frame", 32'(bits), 32'(exp_frame(q.pop_front())));
        end
    endtask

    task automatic wait_data_fall(output int n);
        n = 0;
        while (ps2_data_out !== 1'b0 && n < LIM) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        int          low, span, n, bad;
        bit          tmo;

        step(3);
        reset = 1'b0;
        chk("rst_clk", 32'(ps2_clk_out), 1);
        chk("rst_data", 32'(ps2_data_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ready", 32'(din_ready), 1);

        push(8'hFA);
        chk("fa_busy", 32'(busy), 1);
        get_frame(bits, low, span, tmo);
        chk("fa_timeout", 32'(tmo), 0);
        chk("fa_bits", 32'(bits), 32'h7F4);
        chk("fa_model", 32'(bits), 32'(exp_frame(8'hFA)));
        chk("fa_low_len", 32'(low), HALF);
        chk("fa_span", 32'(span), 21 * HALF);
        step(2);
        chk("fa_idle_busy", 32'(busy), 0);

        push(8'h00);
        push(8'h01);
        get_frame(bits, low, span, tmo);
        chk("p00_parity", 32'(bits[9]), 1);
        chk("p00_stop", 32'(bits[10]), 1);
        chk("p00_frame", 32'(bits), 32'(exp_frame(8'h00)));
        get_frame(bits, low, span, tmo);
        chk("p01_parity", 32'(bits[9]), 0);
        chk("p01_stop", 32'(bits[10]), 1);
        chk("p01_frame", 32'(bits), 32'(exp_frame(8'h01)));

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            push(b);
        end
        drain(3);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i == 7) chk("fill_ready7", 32'(din_ready), 1);
            if (i == 8) chk("fill_ready8", 32'(din_ready), 0);
            if (i == 8) chk("fill_no_ovf", 32'(overflow), 0);
            if (i < 8) q.push_back(b);
            din       = b;
            din_valid = 1'b1;
            step(1);
        end
        din_valid = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        step(1);
        chk("ovf_clear", 32'(overflow), 0);
        drain(8);
        step(2);
        chk("fill_done_busy", 32'(busy), 0);
        chk("fill_done_ready", 32'(din_ready), 1);

        b = 8'($urandom) & 8'hF7;
        push(b);
        for (int k = 0; k < 4; k++) begin
            wait_level(1'b0, n);
            wait_level(1'b1, n);
        end
        step(3);
        host_clk = 1'b0;
        step(SYNC);
        chk("inh_data_rel", 32'(ps2_data_out), 1);
        chk("inh_clk_rel", 32'(ps2_clk_out), 1);
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) bad++;
        end
        chk("inh_quiet", 32'(bad), 0);
        chk("inh_busy", 32'(busy), 1);
        host_clk = 1'b1;
        wait_data_fall(n);
        chk("inh_retry_delay", 32'(n), GAP + SYNC);
        get_frame(bits, low, span, tmo);
        chk("inh_retry_timeout", 32'(tmo), 0);
        chk("inh_retry_frame", 32'(bits), 32'(exp_frame(b)));

        do_reset();
        host_clk = 1'b0;
        b = 8'($urandom);
        push(b);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) bad++;
        end
        chk("idle_inh_quiet", 32'(bad), 0);
        chk("idle_inh_busy", 32'(busy), 1);
        host_clk = 1'b1;
        wait_data_fall(n);
        chk("idle_inh_delay", 32'(n), GAP + SYNC);
        get_frame(bits, low, span, tmo);
        chk("idle_inh_frame", 32'(bits), 32'(exp_frame(b)));

        b = 8'($urandom);
        push(b);
        for (int k = 0; k < 5; k++) begin
            wait_level(1'b0, n);
            wait_level(1'b1, n);
        end
        wait_level(1'b0, n);
        chk("mid_at_bit5", 32'(ps2_clk_out), 0);
        reset = 1'b1;
        step(1);
        chk("mid_rst_clk", 32'(ps2_clk_out), 1);
        chk("mid_rst_data", 32'(ps2_data_out), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(din_ready), 1);
        reset = 1'b0;
        q.delete();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("mid_no_resume", 32'(bad), 0);

        b = 8'($urandom);
        q.push_back(b);
        push(b);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
